// File: rtl/ip_codma_mem_responder_pkg.sv
// rtl/ip_codma_mem_responder_pkg.sv - shared types, constants and request check for the CoDMA memory responder
package codma_mem_pkg;

    typedef enum logic [2:0] {
        RS_IDLE     = 3'd0,
        RS_GNT_WAIT = 3'd1,
        RS_RD_LAT   = 3'd2,
        RS_RD_BURST = 3'd3,
        RS_WR_BURST = 3'd4,
        RS_ERR      = 3'd5
    } resp_state_t;

    localparam int BEAT_BYTES = 8;
    localparam int BEAT_SHIFT = 3;

    // A request is acceptable when it is beat aligned and its last word is
    // inside the array. The end word is formed in 33 bits so a large address
    // plus a burst length can never wrap back into range.
    function automatic logic burst_ok(input logic [31:0] addr,
                                      input logic [3:0]  size,
                                      input int          depth);
        logic [32:0] end_word;
        logic        aligned;
        end_word = {4'b0000, addr[31:BEAT_SHIFT]} + {29'd0, size};
        aligned  = (addr[BEAT_SHIFT-1:0] == 3'b000);
        return aligned && (end_word < 33'(depth));
    endfunction

endpackage

// File: rtl/ip_codma_mem_responder_if.sv
// rtl/ip_codma_mem_responder_if.sv - CoDMA memory port bundle between DMA master and memory responder
interface ip_codma_mem_responder_if;

    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [3:0]  size;
    logic        grant;
    logic [63:0] read_data;
    logic        read_valid;
    logic [63:0] write_data;
    logic        write_valid;
    logic        error;

    modport master (
        output read, write, addr, size, write_data, write_valid,
        input  grant, read_data, read_valid, error
    );

    modport slave (
        input  read, write, addr, size, write_data, write_valid,
        output grant, read_data, read_valid, error
    );

endinterface

// File: rtl/ip_codma_mem_responder_sram.sv
// rtl/ip_codma_mem_responder_sram.sv - single-port synchronous-read 64-bit word array
module codma_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o
);

    logic [63:0] mem [DEPTH_WORDS];

    // Write-first is not needed: the responder never reads a word in the cycle it writes it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/ip_codma_mem_responder.sv
// rtl/ip_codma_mem_responder.sv - CoDMA memory target with configurable grant/read latency and preload port
module ip_codma_mem_responder
    import codma_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int GRANT_DELAY = 1,
    parameter int RD_LATENCY  = 2,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    ip_codma_mem_responder_if.slave     bus,
    input  logic                        pre_we,
    input  logic [AW-1:0]               pre_addr,
    input  logic [63:0]                 pre_wdata
);

    localparam logic [2:0] S_IDLE     = RS_IDLE;
    localparam logic [2:0] S_GNT_WAIT = RS_GNT_WAIT;
    localparam logic [2:0] S_RD_LAT   = RS_RD_LAT;
    localparam logic [2:0] S_RD_BURST = RS_RD_BURST;
    localparam logic [2:0] S_WR_BURST = RS_WR_BURST;
    localparam logic [2:0] S_ERR      = RS_ERR;

    localparam logic [2:0] GD_LAST = 3'((GRANT_DELAY == 0) ? 0 : GRANT_DELAY - 1);
    localparam logic [2:0] RL_LAST = 3'(RD_LATENCY - 1);

    logic [2:0]    state_q, state_d;
    logic [2:0]    cnt_q,   cnt_d;
    logic [3:0]    beat_q,  beat_d;
    logic [3:0]    size_q,  size_d;
    logic [AW-1:0] idx_q,   idx_d;
    logic          dir_q,   dir_d;
    logic          ok_q,    ok_d;
    logic          grant_q, grant_d;
    logic          error_q, error_d;
    logic          rvalid_q, rvalid_d;

    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [63:0]   sram_wdata;
    logic [63:0]   sram_rdata;

    codma_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk_i   (clk_i),
        .we_i    (sram_we),
        .addr_i  (sram_addr),
        .wdata_i (sram_wdata),
        .rdata_o (sram_rdata)
    );

    // Next-state logic and the SRAM port mux. Preload only reaches the array
    // in IDLE; a read issues the address one cycle ahead of its beat.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        size_d     = size_q;
        idx_d      = idx_q;
        dir_d      = dir_q;
        ok_d       = ok_q;
        grant_d    = 1'b0;
        error_d    = 1'b0;
        rvalid_d   = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = pre_addr;
        sram_wdata = pre_wdata;

        case (state_q)
            S_IDLE: begin
                sram_we = pre_we;
                if (bus.read && bus.write) begin
                    // error_q rises with entry to ERR so the pulse lands in ERR itself
                    error_d = 1'b1;
                    state_d = S_ERR;
                end else if (bus.read ^ bus.write) begin
                    dir_d  = bus.write;
                    size_d = bus.size;
                    idx_d  = bus.addr[AW+BEAT_SHIFT-1:BEAT_SHIFT];
                    ok_d   = burst_ok(bus.addr, bus.size, DEPTH_WORDS);
                    cnt_d  = 3'd0;
                    beat_d = 4'd0;
                    if (GRANT_DELAY == 0) begin
                        // zero delay: the answer is due in the very next cycle
                        if (ok_d) begin
                            grant_d = 1'b1;
                            state_d = bus.write ? S_WR_BURST : S_RD_LAT;
                        end else begin
                            error_d = 1'b1;
                            state_d = S_ERR;
                        end
                    end else begin
                        state_d = S_GNT_WAIT;
                    end
                end
            end

            S_GNT_WAIT: begin
                if (cnt_q == GD_LAST) begin
                    cnt_d = 3'd0;
                    if (ok_q) begin
                        grant_d = 1'b1;
                        state_d = dir_q ? S_WR_BURST : S_RD_LAT;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            S_RD_LAT: begin
                if (cnt_q == RL_LAST) begin
                    sram_addr = idx_q;
                    rvalid_d  = 1'b1;
                    idx_d     = idx_q + AW'(1);
                    beat_d    = 4'd0;
                    cnt_d     = 3'd0;
                    state_d   = S_RD_BURST;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            S_RD_BURST: begin
                // beat_q is the beat on the bus this cycle; fetch the next one
                if (beat_q == size_q) begin
                    state_d = S_IDLE;
                end else begin
                    sram_addr = idx_q;
                    rvalid_d  = 1'b1;
                    idx_d     = idx_q + AW'(1);
                    beat_d    = beat_q + 4'd1;
                end
            end

            S_WR_BURST: begin
                if (bus.write_valid) begin
                    sram_we    = 1'b1;
                    sram_addr  = idx_q;
                    sram_wdata = bus.write_data;
                    idx_d      = idx_q + AW'(1);
                    beat_d     = beat_q + 4'd1;
                    if (beat_q == size_q) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_ERR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, latched request and registered strobes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            beat_q   <= 4'd0;
            size_q   <= 4'd0;
            idx_q    <= '0;
            dir_q    <= 1'b0;
            ok_q     <= 1'b0;
            grant_q  <= 1'b0;
            error_q  <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            size_q   <= size_d;
            idx_q    <= idx_d;
            dir_q    <= dir_d;
            ok_q     <= ok_d;
            grant_q  <= grant_d;
            error_q  <= error_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.error      = error_q;
    assign bus.read_valid = rvalid_q;
    // The array output register is not reset, so hold the data bus at zero between beats.
    assign bus.read_data  = rvalid_q ? sram_rdata : 64'd0;

endmodule

// File: tb/tb_ip_codma_mem_responder.sv
// tb/tb_ip_codma_mem_responder.sv - directed self-checking bench for ip_codma_mem_responder
module tb_ip_codma_mem_responder;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk_i     = 1'b0;
    logic          reset_i   = 1'b1;
    logic          pre_we    = 1'b0;
    logic [AW-1:0] pre_addr  = '0;
    logic [63:0]   pre_wdata = '0;

    ip_codma_mem_responder_if bus();

    ip_codma_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .GRANT_DELAY (1),
        .RD_LATENCY  (2)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .bus       (bus),
        .pre_we    (pre_we),
        .pre_addr  (pre_addr),
        .pre_wdata (pre_wdata)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          g_cyc, e_cyc, b0_cyc, bl_cyc, nbeat, n_grant, n_err;
    int          n_overlap = 0;
    logic [63:0] rbuf [16];
    logic [63:0] wbuf [16];

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and watch 40 cycles; cycle 0 is the cycle the request is first seen.
    task automatic xact(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] s, input bit gap);
        int  wi;
        bit  gap_done;
        g_cyc = -1; e_cyc = -1; b0_cyc = -1; bl_cyc = -1;
        nbeat = 0; n_grant = 0; n_err = 0;
        wi = 0; gap_done = 0;
        @(posedge clk_i);
        #1;
        bus.read  = rd;
        bus.write = wr;
        bus.addr  = a;
        bus.size  = s;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if ((int'(bus.grant) + int'(bus.error) + int'(bus.read_valid)) > 1) n_overlap++;
            if (bus.grant) begin
                n_grant++;
                if (g_cyc < 0) g_cyc = c;
            end
            if (bus.error) begin
                n_err++;
                if (e_cyc < 0) e_cyc = c;
            end
            if (bus.read_valid) begin
                if (nbeat == 0) b0_cyc = c;
                if (nbeat < 16) rbuf[nbeat] = bus.read_data;
                nbeat++;
                bl_cyc = c;
            end
            if (bus.grant || bus.error) begin
                bus.read  = 1'b0;
                bus.write = 1'b0;
            end
            bus.write_valid = 1'b0;
            if (wr && !rd && g_cyc >= 0) begin
                if (gap && wi == 1 && !gap_done) begin
                    gap_done = 1;
                end else if (wi <= int'(s)) begin
                    bus.write_valid = 1'b1;
                    bus.write_data  = wbuf[wi];
                    wi++;
                end
            end
        end
        bus.read        = 1'b0;
        bus.write       = 1'b0;
        bus.write_valid = 1'b0;
    endtask

    initial begin
        bus.read        = 1'b0;
        bus.write       = 1'b0;
        bus.addr        = '0;
        bus.size        = '0;
        bus.write_data  = '0;
        bus.write_valid = 1'b0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        expect_eq("rst_grant",  bus.grant,      0);
        expect_eq("rst_error",  bus.error,      0);
        expect_eq("rst_rvalid", bus.read_valid, 0);
        expect_eq("rst_rdata",  bus.read_data,  0);
        reset_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            pre_we    = 1'b1;
            pre_addr  = AW'(i);
            pre_wdata = 64'h1111 * 64'(i + 1);
        end
        @(negedge clk_i);
        pre_we = 1'b0;

        // read burst of four preloaded words
        xact(1'b1, 1'b0, 32'h0, 4'd3, 1'b0);
        expect_eq("rd_grant_cyc", 64'(g_cyc),   2);
        expect_eq("rd_grant_cnt", 64'(n_grant), 1);
        expect_eq("rd_err_cnt",   64'(n_err),   0);
        expect_eq("rd_beat0_cyc", 64'(b0_cyc),  4);
        expect_eq("rd_beat_last", 64'(bl_cyc),  7);
        expect_eq("rd_nbeat",     64'(nbeat),   4);
        expect_eq("rd_d0", rbuf[0], 64'h1111);
        expect_eq("rd_d1", rbuf[1], 64'h2222);
        expect_eq("rd_d2", rbuf[2], 64'h3333);
        expect_eq("rd_d3", rbuf[3], 64'h4444);

        // write two beats with a gap, then read them back
        wbuf[0] = 64'hDEAD_BEEF_0000_0001;
        wbuf[1] = 64'hDEAD_BEEF_0000_0002;
        xact(1'b0, 1'b1, 32'h40, 4'd1, 1'b1);
        expect_eq("wr_grant_cyc", 64'(g_cyc),   2);
        expect_eq("wr_err_cnt",   64'(n_err),   0);
        expect_eq("wr_no_rvalid", 64'(nbeat),   0);
        xact(1'b1, 1'b0, 32'h40, 4'd1, 1'b0);
        expect_eq("wb_nbeat", 64'(nbeat), 2);
        expect_eq("wb_d0", rbuf[0], 64'hDEAD_BEEF_0000_0001);
        expect_eq("wb_d1", rbuf[1], 64'hDEAD_BEEF_0000_0002);

        // misaligned read
        xact(1'b1, 1'b0, 32'h44, 4'd0, 1'b0);
        expect_eq("mis_err_cyc", 64'(e_cyc),   2);
        expect_eq("mis_err_cnt", 64'(n_err),   1);
        expect_eq("mis_grant",   64'(n_grant), 0);
        expect_eq("mis_rvalid",  64'(nbeat),   0);

        // burst running past the last word, then a single beat at the last word
        xact(1'b0, 1'b1, 32'h1FF8, 4'd1, 1'b0);
        expect_eq("oor_err_cyc", 64'(e_cyc),   2);
        expect_eq("oor_grant",   64'(n_grant), 0);
        wbuf[0] = 64'hA5A5_0000_0000_1FF8;
        xact(1'b0, 1'b1, 32'h1FF8, 4'd0, 1'b0);
        expect_eq("edge_grant_cyc", 64'(g_cyc), 2);
        expect_eq("edge_err_cnt",   64'(n_err), 0);
        xact(1'b1, 1'b0, 32'h1FF8, 4'd0, 1'b0);
        expect_eq("edge_nbeat", 64'(nbeat), 1);
        expect_eq("edge_d0", rbuf[0], 64'hA5A5_0000_0000_1FF8);

        // read and write together
        xact(1'b1, 1'b1, 32'h0, 4'd0, 1'b0);
        expect_eq("both_err_cnt", 64'(n_err),   1);
        expect_eq("both_grant",   64'(n_grant), 0);
        expect_eq("both_rvalid",  64'(nbeat),   0);

        // reset during beat 2 of an 8-beat read
        nbeat = 0;
        @(posedge clk_i);
        #1;
        bus.read = 1'b1;
        bus.addr = 32'h0;
        bus.size = 4'd7;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (bus.grant) bus.read = 1'b0;
            if (bus.read_valid) nbeat++;
            if (nbeat == 2) break;
        end
        bus.read = 1'b0;
        expect_eq("mid_reached_beat2", 64'(nbeat), 2);
        #1;
        reset_i = 1'b1;
        #1;
        expect_eq("mid_rvalid", bus.read_valid, 0);
        expect_eq("mid_grant",  bus.grant,      0);
        expect_eq("mid_error",  bus.error,      0);
        @(negedge clk_i);
        reset_i = 1'b0;

        xact(1'b1, 1'b0, 32'h0, 4'd7, 1'b0);
        expect_eq("post_nbeat", 64'(nbeat), 8);
        for (int i = 0; i < 8; i++) begin
            expect_eq($sformatf("post_d%0d", i), rbuf[i], 64'h1111 * 64'(i + 1));
        end

        expect_eq("exclusive_strobes", 64'(n_overlap), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
